// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Shared definitions for the multi-approach traffic-light controller:
//   the phase codes reported on phase_o and the default phase durations.
package traffic_pkg;

   typedef enum logic [2:0] {
      PH_ALLRED = 3'd0,
      PH_GREEN  = 3'd1,
      PH_YELLOW = 3'd2,
      PH_WALK   = 3'd3,
      PH_FLASH  = 3'd4
   } phase_e;

   localparam int DEF_NUM_DIR  = 2;
   localparam int DEF_TICK_DIV = 1000;
   localparam int DEF_GREEN_T  = 10;
   localparam int DEF_YELLOW_T = 3;
   localparam int DEF_ALLRED_T = 1;
   localparam int DEF_WALK_T   = 5;
   localparam int DEF_TW       = 8;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
//   Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
//   The count freezes while ena is low, so a tick due at the terminal
//   count is delivered on the first enabled cycle afterwards.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset (count returns to 0)
//   ena     advance enable
//   tick_o  single-cycle tick, high when count is terminal and ena=1
module tick_prescaler #(
   parameter int TICK_DIV = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   output logic tick_o
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          at_last;

   assign at_last = (cnt_q == CNT_LAST);
   assign tick_o  = at_last && ena;

   always_comb begin
      cnt_d = cnt_q;
      if (ena) begin
         cnt_d = at_last ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/traffic_light_ctrl_n.sv
// traffic_light_ctrl_n
//   Multi-approach traffic-light controller: prescaled tick, down-counting
//   phase timer, demand-driven round-robin approach selection, optional
//   exclusive pedestrian phase and a flashing-yellow fault/night mode.
//   All lamp outputs are registered and change on the same edge as the state.
// Build option:
//   TRAFFIC_PED_EN  defined -> pedestrian pending latch, WALK phase and walk_o
//                   live; undefined -> ped_req_i ignored, walk_o held at 0.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ena               advance enable (low freezes prescaler, timer, state)
//   demand_i          per-approach vehicle demand (level)
//   ped_req_i         per-approach pedestrian button (level)
//   flash_i           flashing-yellow mode request (sampled on ticks)
//   red_o/yellow_o/green_o/walk_o  lamp drives per approach
//   active_o          approach owning green/yellow
//   phase_o           phase code (see traffic_pkg::phase_e)
//
// state     | meaning
// ----------+------------------------------------------------------------
// PH_ALLRED | all red clearance; then WALK (ped pending), GREEN or FLASH
// PH_GREEN  | active approach green; flash request cuts it short to YELLOW
// PH_YELLOW | active approach yellow; then ALLRED or FLASH
// PH_WALK   | all red, walk lamps from pending snapshot; then GREEN or FLASH
// PH_FLASH  | all yellow blinking per tick; flash_i low on a tick -> ALLRED
module traffic_light_ctrl_n
   import traffic_pkg::*;
#(
   parameter int NUM_DIR  = DEF_NUM_DIR,
   parameter int TICK_DIV = DEF_TICK_DIV,
   parameter int GREEN_T  = DEF_GREEN_T,
   parameter int YELLOW_T = DEF_YELLOW_T,
   parameter int ALLRED_T = DEF_ALLRED_T,
   parameter int WALK_T   = DEF_WALK_T,
   parameter int TW       = DEF_TW
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic [NUM_DIR-1:0] demand_i,
   input  logic [NUM_DIR-1:0] ped_req_i,
   input  logic               flash_i,
   output logic [NUM_DIR-1:0] red_o,
   output logic [NUM_DIR-1:0] yellow_o,
   output logic [NUM_DIR-1:0] green_o,
   output logic [NUM_DIR-1:0] walk_o,
   output logic [1:0]         active_o,
   output logic [2:0]         phase_o
);

   localparam logic [TW-1:0] GREEN_LD  = TW'(GREEN_T);
   localparam logic [TW-1:0] YELLOW_LD = TW'(YELLOW_T);
   localparam logic [TW-1:0] ALLRED_LD = TW'(ALLRED_T);
   localparam logic [TW-1:0] WALK_LD   = TW'(WALK_T);
   localparam logic [1:0]    LAST_DIR  = 2'(NUM_DIR - 1);

   logic tick;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .tick_o (tick)
   );

   phase_e               phase_q, phase_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [1:0]           active_q, active_d;
   logic [NUM_DIR-1:0]   ped_pend_q, ped_pend_d;
   logic [NUM_DIR-1:0]   walk_q, walk_d;
   logic                 flash_lit_q, flash_lit_d;
   logic                 flash_req_q, flash_req_d;
   logic [NUM_DIR-1:0]   red_q, red_d;
   logic [NUM_DIR-1:0]   yellow_q, yellow_d;
   logic [NUM_DIR-1:0]   green_q, green_d;

   logic                 ped_any;
   logic                 clr_pend;
   logic                 go_flash;
   logic                 to_flash;

   // Round-robin pick: first demanding approach after active_q, wrapping
   // back to active_q itself; with no demand at all, simply step by one.
   logic [3:0] dem4;
   logic [1:0] next_dir;
   logic [1:0] cand;
   logic       found;

   assign dem4 = 4'(demand_i);

   always_comb begin
      next_dir = 2'((int'(active_q) + 1) % NUM_DIR);
      found    = 1'b0;
      cand     = '0;
      for (int k = 1; k <= NUM_DIR; k++) begin
         cand = 2'((int'(active_q) + k) % NUM_DIR);
         if (!found && dem4[cand]) begin
            next_dir = cand;
            found    = 1'b1;
         end
      end
   end

`ifdef TRAFFIC_PED_EN
   assign ped_any = |ped_pend_q;

   // Requests seen on the WALK entry edge are kept for the next cycle.
   always_comb begin
      ped_pend_d = clr_pend ? '0 : ped_pend_q;
      if (ena) begin
         ped_pend_d = ped_pend_d | ped_req_i;
      end
   end
`else
   logic unused_ped;

   assign ped_any    = 1'b0;
   assign ped_pend_d = '0;
   assign unused_ped = ^{ped_req_i, clr_pend};
`endif

   // A flash request seen on any tick is remembered until FLASH is entered,
   // so the current phase can finish normally first.
   assign go_flash = flash_req_q | flash_i;

   always_comb begin
      phase_d     = phase_q;
      timer_d     = timer_q;
      active_d    = active_q;
      walk_d      = walk_q;
      flash_lit_d = flash_lit_q;
      flash_req_d = flash_req_q;
      clr_pend    = 1'b0;
      to_flash    = 1'b0;

      if (tick) begin
         if (phase_q == PH_FLASH) begin
            if (!flash_i) begin
               phase_d = PH_ALLRED;
               timer_d = ALLRED_LD;
            end else begin
               flash_lit_d = ~flash_lit_q;
            end
         end else begin
            if (flash_i) begin
               flash_req_d = 1'b1;
            end
            if (phase_q == PH_GREEN && flash_i) begin
               phase_d = PH_YELLOW;
               timer_d = YELLOW_LD;
            end else if (timer_q == TW'(1)) begin
               case (phase_q)
                  PH_ALLRED: begin
                     if (go_flash) begin
                        to_flash = 1'b1;
                     end else if (ped_any) begin
                        phase_d  = PH_WALK;
                        timer_d  = WALK_LD;
                        walk_d   = ped_pend_q;
                        clr_pend = 1'b1;
                     end else begin
                        phase_d  = PH_GREEN;
                        timer_d  = GREEN_LD;
                        active_d = next_dir;
                     end
                  end
                  PH_GREEN: begin
                     phase_d = PH_YELLOW;
                     timer_d = YELLOW_LD;
                  end
                  PH_YELLOW: begin
                     if (go_flash) begin
                        to_flash = 1'b1;
                     end else begin
                        phase_d = PH_ALLRED;
                        timer_d = ALLRED_LD;
                     end
                  end
                  PH_WALK: begin
                     walk_d = '0;
                     if (go_flash) begin
                        to_flash = 1'b1;
                     end else begin
                        phase_d  = PH_GREEN;
                        timer_d  = GREEN_LD;
                        active_d = next_dir;
                     end
                  end
                  default: begin
                     phase_d = PH_ALLRED;
                     timer_d = ALLRED_LD;
                  end
               endcase
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
      end

      if (to_flash) begin
         phase_d     = PH_FLASH;
         flash_lit_d = 1'b1;
         flash_req_d = 1'b0;
         walk_d      = '0;
      end
   end

   // Lamps decoded from next state so they register alongside it.
   logic [NUM_DIR-1:0] own_d;

   assign own_d = {{(NUM_DIR-1){1'b0}}, 1'b1} << active_d;

   always_comb begin
      red_d    = '1;
      yellow_d = '0;
      green_d  = '0;
      case (phase_d)
         PH_GREEN: begin
            green_d = own_d;
            red_d   = ~own_d;
         end
         PH_YELLOW: begin
            yellow_d = own_d;
            red_d    = ~own_d;
         end
         PH_FLASH: begin
            red_d    = '0;
            yellow_d = {NUM_DIR{flash_lit_d}};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q     <= PH_ALLRED;
         timer_q     <= ALLRED_LD;
         active_q    <= LAST_DIR;
         ped_pend_q  <= '0;
         walk_q      <= '0;
         flash_lit_q <= 1'b0;
         flash_req_q <= 1'b0;
         red_q       <= '1;
         yellow_q    <= '0;
         green_q     <= '0;
      end else begin
         phase_q     <= phase_d;
         timer_q     <= timer_d;
         active_q    <= active_d;
         ped_pend_q  <= ped_pend_d;
         walk_q      <= walk_d;
         flash_lit_q <= flash_lit_d;
         flash_req_q <= flash_req_d;
         red_q       <= red_d;
         yellow_q    <= yellow_d;
         green_q     <= green_d;
      end
   end

   assign red_o    = red_q;
   assign yellow_o = yellow_q;
   assign green_o  = green_q;
   assign walk_o   = walk_q;
   assign active_o = active_q;
   assign phase_o  = phase_q;

endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
module tb_traffic_light_ctrl_n;

   localparam int N  = 2;
   localparam int TD = 4;
   localparam int GT = 3;
   localparam int YT = 2;
   localparam int AT = 1;
   localparam int WT = 2;
   localparam int TW = 8;
`ifdef TRAFFIC_PED_EN
   localparam int PED_EN = 1;
`else
   localparam int PED_EN = 0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         ena = 1'b1;
   logic         flash_i = 1'b0;
   logic [N-1:0] demand_i = '0;
   logic [N-1:0] ped_req_i = '0;
   logic [N-1:0] red_o, yellow_o, green_o, walk_o;
   logic [1:0]   active_o;
   logic [2:0]   phase_o;

   int errors = 0;
   int checks = 0;

   traffic_light_ctrl_n #(
      .NUM_DIR(N), .TICK_DIV(TD), .GREEN_T(GT), .YELLOW_T(YT),
      .ALLRED_T(AT), .WALK_T(WT), .TW(TW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .demand_i(demand_i),
      .ped_req_i(ped_req_i), .flash_i(flash_i), .red_o(red_o),
      .yellow_o(yellow_o), .green_o(green_o), .walk_o(walk_o),
      .active_o(active_o), .phase_o(phase_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: phase codes 0..4, ticks remaining, owner, etc.
   int m_cnt, m_left, m_phase, m_act, m_lit, m_freq, m_pend, m_walk;

   function automatic int pick_next(input int act, input int dem);
      for (int k = 1; k <= N; k++) begin
         if (((dem >> ((act + k) % N)) & 1) != 0) return (act + k) % N;
      end
      return (act + 1) % N;
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_left = AT; m_phase = 0; m_act = N - 1;
      m_lit = 0; m_freq = 0; m_pend = 0; m_walk = 0;
   endtask

   task automatic model_step();
      int tick, gof, to_fl, dem;
      dem   = int'(demand_i);
      tick  = (ena && m_cnt == TD - 1) ? 1 : 0;
      to_fl = 0;
      if (ena) m_cnt = (m_cnt == TD - 1) ? 0 : m_cnt + 1;
      if (tick != 0) begin
         if (m_phase == 4) begin
            if (!flash_i) begin m_phase = 0; m_left = AT; end
            else m_lit = 1 - m_lit;
         end else begin
            gof = (m_freq != 0 || flash_i) ? 1 : 0;
            if (flash_i) m_freq = 1;
            if (m_phase == 1 && flash_i) begin
               m_phase = 2; m_left = YT;
            end else if (m_left == 1) begin
               if (m_phase == 0) begin
                  if (gof != 0) to_fl = 1;
                  else if (PED_EN != 0 && m_pend != 0) begin
                     m_phase = 3; m_left = WT; m_walk = m_pend; m_pend = 0;
                  end else begin
                     m_act = pick_next(m_act, dem); m_phase = 1; m_left = GT;
                  end
               end else if (m_phase == 1) begin
                  m_phase = 2; m_left = YT;
               end else if (m_phase == 2) begin
                  if (gof != 0) to_fl = 1;
                  else begin m_phase = 0; m_left = AT; end
               end else begin
                  m_walk = 0;
                  if (gof != 0) to_fl = 1;
                  else begin
                     m_act = pick_next(m_act, dem); m_phase = 1; m_left = GT;
                  end
               end
            end else begin
               m_left = m_left - 1;
            end
         end
      end
      if (to_fl != 0) begin
         m_phase = 4; m_lit = 1; m_freq = 0; m_walk = 0;
      end
      if (ena && PED_EN != 0) m_pend = m_pend | int'(ped_req_i);
   endtask

   task automatic compare_all();
      int eg, ey, er;
      eg = (m_phase == 1) ? (1 << m_act) : 0;
      ey = (m_phase == 2) ? (1 << m_act) : ((m_phase == 4 && m_lit != 0) ? 3 : 0);
      er = (m_phase == 4) ? 0 : (3 & ~(eg | ey));
      chk("red_o", 32'(red_o), er);
      chk("yellow_o", 32'(yellow_o), ey);
      chk("green_o", 32'(green_o), eg);
      chk("walk_o", 32'(walk_o), m_walk);
      chk("active_o", 32'(active_o), m_act);
      chk("phase_o", 32'(phase_o), m_phase);
      chk("safety", 32'(($countones(green_o) > 1) || (green_o != 0 && walk_o != 0)), 0);
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
         #1;
         compare_all();
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_phase(input int p, input int maxc, input string nm);
      int n;
      n = 0;
      while (int'(phase_o) != p && n < maxc) begin
         cyc();
         n++;
      end
      chk(nm, 32'(phase_o), p);
   endtask

   logic [1:0] gs[1:28], ys[1:28], rs[1:28], as_[1:28];
   logic [2:0] ps[1:28];
   int g0, g1, cnt, n, c, stop;

   initial begin
      // reset values while rst_n is held
      repeat (3) cyc();
      chk("rst_red", 32'(red_o), 3);
      chk("rst_green", 32'(green_o), 0);
      chk("rst_walk", 32'(walk_o), 0);
      chk("rst_active", 32'(active_o), 1);
      chk("rst_phase", 32'(phase_o), 0);

      // fixed-time sequence with no demand
      @(negedge clk) rst_n = 1'b1;
      for (int e = 1; e <= 28; e++) begin
         cyc();
         gs[e] = green_o; ys[e] = yellow_o; rs[e] = red_o;
         ps[e] = phase_o; as_[e] = active_o;
      end
      chk("s1_allred_e3", 32'(ps[3]), 0);
      chk("s1_green_e4", 32'(gs[4]), 1);
      chk("s1_green_e15", 32'(gs[15]), 1);
      chk("s1_yellow_e16", 32'(ys[16]), 1);
      chk("s1_green_off_e16", 32'(gs[16]), 0);
      chk("s1_yellow_e23", 32'(ys[23]), 1);
      chk("s1_allred_e24", 32'(rs[24]), 3);
      chk("s1_allred_e27", 32'(ps[27]), 0);
      chk("s1_green_e28", 32'(gs[28]), 2);
      chk("s1_active_e28", 32'(as_[28]), 1);

      // demand only on approach 0
      @(negedge clk) demand_i = 2'b01;
      cyc();
      n = 0;
      while (!(phase_o == 3'd1 && active_o == 2'd0) && n < 60) begin cyc(); n++; end
      chk("s2_reach", 32'(phase_o == 3'd1 && active_o == 2'd0), 1);
      g0 = 0; g1 = 0;
      for (int i = 0; i < 200; i++) begin
         if (green_o[0]) g0++;
         if (green_o[1]) g1++;
         cyc();
      end
      chk("s2_green1_cycles", g1, 0);
      chk("s2_green0_cycles", g0, 104);

      // single pedestrian pulse during green
      wait_phase(1, 60, "s3_green");
      @(negedge clk) ped_req_i = 2'b10;
      @(negedge clk) ped_req_i = 2'b00;
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         cyc();
         if (walk_o == 2'b10) cnt++;
      end
      chk("s3_walk_cycles", cnt, PED_EN * 8);

      // flash request mid-green
      wait_phase(1, 60, "s4_green");
      @(negedge clk) flash_i = 1'b1;
      cnt = 0; n = 0;
      while (phase_o != 3'd4 && n < 60) begin
         cyc();
         if (phase_o == 3'd2) cnt++;
         n++;
      end
      chk("s4_flash_reach", 32'(phase_o), 4);
      chk("s4_yellow_cycles", cnt, 8);
      chk("s4_flash_lit", 32'(yellow_o), 3);
      chk("s4_flash_red", 32'(red_o), 0);
      repeat (4) cyc();
      chk("s4_flash_dark", 32'(yellow_o), 0);
      repeat (4) cyc();
      chk("s4_flash_relit", 32'(yellow_o), 3);
      @(negedge clk) flash_i = 1'b0;
      wait_phase(0, 20, "s4_allred_reach");
      cnt = 0;
      while (phase_o == 3'd0 && cnt < 20) begin cnt++; cyc(); end
      chk("s4_allred_cycles", cnt, 4);
      chk("s4_green_after", 32'(phase_o), 1);

      // ena low for 10 cycles mid-yellow
      wait_phase(2, 80, "s5_yellow");
      cnt = 1; c = 1; stop = 0;
      while (stop == 0 && c < 60) begin
         @(negedge clk) ena = (c >= 3 && c < 13) ? 1'b0 : 1'b1;
         cyc();
         if (phase_o == 3'd2) cnt++;
         else stop = 1;
         c++;
      end
      ena = 1'b1;
      chk("s5_yellow_cycles", cnt, 18);

      // asynchronous reset mid-walk (mid-green without the ped phase)
      @(negedge clk) ped_req_i = 2'b01;
      @(negedge clk) ped_req_i = 2'b00;
      wait_phase(PED_EN != 0 ? 3 : 1, 80, "s6_phase");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("s6_red", 32'(red_o), 3);
      chk("s6_walk", 32'(walk_o), 0);
      chk("s6_phase0", 32'(phase_o), 0);
      chk("s6_green", 32'(green_o), 0);
      @(negedge clk) rst_n = 1'b1;

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         demand_i  = 2'($urandom);
         ped_req_i = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
         if ($urandom_range(0, 149) == 0) flash_i = ~flash_i;
         ena = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 999) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk) rst_n = 1'b1;
         end
      end
      flash_i = 1'b0;
      repeat (2) cyc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/traffic_light_ctrl_n.md
# traffic_light_ctrl_n

Parametrised multi-direction traffic-light controller. It generalises the fixed two-way light to NUM_DIR approaches, with:
- programmable phase durations driven by a prescaled tick;
- demand-driven round-robin direction selection;
- an optional exclusive pedestrian phase;
- a flashing-yellow fault/night mode.

It sits directly behind the TinyTapeout top wrapper, which maps its lamp outputs onto uo_out/uio_out.

## Interface
- NUM_DIR, 2: number of approaches, legal 2..4
- TICK_DIV, 1000: clk cycles per tick, ≥1
- GREEN_T, 10: green duration in ticks, ≥1
- YELLOW_T, 3: yellow duration in ticks, ≥1
- ALLRED_T, 1: all-red clearance in ticks, ≥1
- WALK_T, 5: pedestrian walk duration in ticks, ≥1
- TW, 8: timer width; every duration must be < 2^TW
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  advance enable; low freezes prescaler, timer and state
- demand_i  in  NUM_DIR  vehicle-present sensor per approach, level
- ped_req_i  in  NUM_DIR  pedestrian button per approach, level
- flash_i  in  1  request flashing-yellow mode
- red_o / yellow_o / green_o  out  NUM_DIR each  lamp drives
- walk_o  out  NUM_DIR  pedestrian walk lamps
- active_o  out  2  index of the approach owning green/yellow
- phase_o  out  3  state code: ALLRED=0, GREEN=1, YELLOW=2, WALK=3, FLASH=4

## Operation
- Reset values:
  - state ALLRED, timer = ALLRED_T, prescaler 0;
  - active_o = NUM_DIR-1, so the first green goes to approach 0 when it has demand or no approach does;
  - red_o all 1s; yellow_o, green_o and walk_o all 0; ped pending all 0.
- Tick: prescaler counts 0..TICK_DIV-1 while ena=1; tick = (count==TICK_DIV-1)&&ena.
- Timer: decrements on tick. A phase ends on the tick where timer==1, and the next phase's duration is loaded on that edge.
- Transitions:
  - ALLRED→WALK if any ped pending (PED_EN); otherwise →GREEN of the next approach.
  - GREEN→YELLOW; YELLOW→ALLRED; WALK→GREEN of the next approach.
- Next approach: search cyclically from active_o+1 for the first approach with demand_i=1, sampled on the transition edge. If none has demand, use active_o+1 mod NUM_DIR (fixed-time fallback). active_o updates on entry to GREEN only.
- Lamps:
  - GREEN/YELLOW: only approach active_o lit green/yellow; all others red.
  - ALLRED and WALK: all red.
- Ped: ped_pend |= ped_req_i every enabled cycle. On WALK entry, walk_o = ped_pend snapshot, and those bits clear. Requests arriving during WALK stay pending for the next cycle.
- Flash:
  - flash_i sampled only on ticks.
  - If seen during GREEN: force YELLOW with timer reloaded to YELLOW_T.
  - In YELLOW, ALLRED or WALK the phase completes normally, then enters FLASH instead of its normal successor.
  - In FLASH: red, green and walk all 0; all yellow_o toggle on each tick, starting lit.
  - flash_i=0 on a tick in FLASH → ALLRED with timer = ALLRED_T; active_o and ped_pend are retained.
- Safety invariant: at no time are two approaches green, or any green concurrent with any walk.

## Timing
- All outputs are registered and change on the same edge as the state.
- With ena held high, a D-tick phase lasts exactly D*TICK_DIV cycles. The first transition occurs ALLRED_T*TICK_DIV cycles after rst_n deasserts.
- ena low: everything holds; a tick pending at count==TICK_DIV-1 fires on the first enabled cycle.
- rst_n asserted mid-phase: immediate return to the reset values above, asynchronously.
- demand_i and ped_req_i are already synchronised upstream and have no latency requirement beyond one cycle.

## Configuration
- TRAFFIC_PED_EN defined: ped_pend logic, the WALK state and walk_o are live.
- TRAFFIC_PED_EN not defined:
  - ped_req_i is ignored and walk_o is tied to 0;
  - WALK is unreachable and ALLRED always goes to GREEN;
  - ports remain present so the testbench is unchanged.

## Structure
- Package traffic_pkg holds the phase_e enum (codes above) and the default duration constants.
- Sub-module tick_prescaler (TICK_DIV, ena → tick).
- Selection logic and the FSM live in traffic_light_ctrl_n.

## Test plan
All scenarios use NUM_DIR=2, TICK_DIV=4, GREEN_T=3, YELLOW_T=2, ALLRED_T=1, WALK_T=2.
- Reset, demand=0, ena=1 → ALLRED 4 cycles, green_o=01 for 12 cycles, yellow_o=01 for 8 cycles, ALLRED 4 cycles, then green_o=10.
- demand_i=01 held → approach 1 is never green; green_o alternates 01 / ALLRED only.
- Pulse ped_req_i=10 for 1 cycle during GREEN → after the following ALLRED, walk_o=10 for 8 cycles with all red, then GREEN; pending clears.
- flash_i=1 mid-GREEN → YELLOW (8 cycles), then FLASH with yellow_o alternating 11/00 every 4 cycles. flash_i=0 → ALLRED 4 cycles, then GREEN.
- ena=0 for 10 cycles mid-YELLOW → outputs frozen, and YELLOW ends 10 cycles late.
- rst_n low mid-WALK → red_o=11, walk_o=00 and phase_o=0 immediately, without waiting for a clock edge.
